// File: rtl/knn_mul_share_ctrl.sv
// Round-robin front end that time-shares one two-stage pipelined multiplier among NUM_REQ lanes.
// Requester tags ride alongside the multiplier pipeline so each product returns with its lane id.
module knn_mul_share_ctrl #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned ID_WIDTH    = 2,
  parameter int unsigned A_WIDTH     = 17,
  parameter int unsigned B_WIDTH     = 15,
  parameter int unsigned P_WIDTH     = 32,
  parameter int unsigned MUL_LATENCY = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*A_WIDTH-1:0] req_a,
  input  logic [NUM_REQ*B_WIDTH-1:0] req_b,
  output logic                       mul_ce,
  output logic [A_WIDTH-1:0]         mul_din0,
  output logic [B_WIDTH-1:0]         mul_din1,
  input  logic [P_WIDTH-1:0]         mul_dout,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [P_WIDTH-1:0]         rsp_data,
  output logic [ID_WIDTH-1:0]        rsp_id
);

  logic [ID_WIDTH-1:0]    rr_ptr_q;
  logic [ID_WIDTH-1:0]    rr_ptr_d;
  logic [MUL_LATENCY-1:0] vld_q;
  logic [ID_WIDTH-1:0]    id_q [MUL_LATENCY];
  logic [2*NUM_REQ-1:0]   rot;
  logic                   grant_vld;
  logic [ID_WIDTH-1:0]    grant_id;

  // A full output register with no taker freezes everything upstream.
  assign mul_ce    = ~rsp_valid | rsp_ready;
  assign rsp_valid = vld_q[MUL_LATENCY-1];
  assign rsp_id    = id_q[MUL_LATENCY-1];
  assign rsp_data  = mul_dout;

  // Rotate so bit 0 is the lane at the round-robin pointer.
  assign rot = {req_valid, req_valid} >> rr_ptr_q;

  always_comb begin
    grant_vld = 1'b0;
    grant_id  = '0;
    if (mul_ce) begin
      for (int k = 0; k < int'(NUM_REQ); k++) begin
        if (!grant_vld && rot[k]) begin
          grant_vld = 1'b1;
          grant_id  = ID_WIDTH'((int'(rr_ptr_q) + k) % int'(NUM_REQ));
        end
      end
    end
  end

  always_comb begin
    req_ready = '0;
    mul_din0  = '0;
    mul_din1  = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (grant_vld && (grant_id == ID_WIDTH'(i))) begin
        req_ready[i] = 1'b1;
        mul_din0     = req_a[i*A_WIDTH +: A_WIDTH];
        mul_din1     = req_b[i*B_WIDTH +: B_WIDTH];
      end
    end
  end

  assign rr_ptr_d = ID_WIDTH'((int'(grant_id) + 1) % int'(NUM_REQ));

  always_ff @(posedge clk) begin
    if (!reset) begin
      rr_ptr_q <= '0;
      vld_q    <= '0;
      for (int i = 0; i < int'(MUL_LATENCY); i++) begin
        id_q[i] <= '0;
      end
    end else if (mul_ce) begin
      if (grant_vld) begin
        rr_ptr_q <= rr_ptr_d;
      end
      vld_q[0] <= grant_vld;
      id_q[0]  <= grant_id;
      for (int i = 1; i < int'(MUL_LATENCY); i++) begin
        vld_q[i] <= vld_q[i-1];
        id_q[i]  <= id_q[i-1];
      end
    end
  end

endmodule

// File: tb/tb_knn_mul_share_ctrl.sv
// Directed bench for knn_mul_share_ctrl with a behavioural two-stage ce-gated multiplier.
module tb_knn_mul_share_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [67:0] req_a;
  logic [59:0] req_b;
  logic        mul_ce;
  logic [16:0] mul_din0;
  logic [14:0] mul_din1;
  logic [31:0] mul_dout;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_id;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  knn_mul_share_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .mul_ce    (mul_ce),
    .mul_din0  (mul_din0),
    .mul_din1  (mul_din1),
    .mul_dout  (mul_dout),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id)
  );

  // External multiplier: no reset, two ce-gated stages.
  logic [31:0] m1, m2;
  always_ff @(posedge clk) begin
    if (mul_ce) begin
      m1 <= 32'(mul_din0) * 32'(mul_din1);
      m2 <= m1;
    end
  end
  assign mul_dout = m2;

  // Full-load phase with a 3-cycle backpressure window at cycles 5..7.
  localparam int FlRspReady [15] = '{1, 1, 1, 1, 1, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1};
  localparam int FlReady    [15] = '{1, 2, 4, 8, 1, 0, 0, 0, 2, 4, 8, 1, 0, 0, 0};
  localparam int FlCe       [15] = '{1, 1, 1, 1, 1, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1};
  localparam int FlRv       [15] = '{0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0};
  localparam int FlId       [15] = '{0, 0, 0, 1, 2, 3, 3, 3, 3, 0, 1, 2, 3, 0, 0};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic set_lane(input int i, input logic [16:0] a, input logic [14:0] b);
    req_a[i*17 +: 17] = a;
    req_b[i*15 +: 15] = b;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // One isolated request, then its response exactly two cycles after the accept edge.
  task automatic single(input int lane, input logic [16:0] a, input logic [14:0] b,
                        input logic [3:0] exp_ready, input logic [31:0] exp_data);
    set_lane(lane, a, b);
    req_valid = exp_ready;
    rsp_ready = 1'b1;
    @(negedge clk);
    check("single_ready", req_ready, exp_ready);
    check("single_din0", mul_din0, a);
    check("single_din1", mul_din1, b);
    next_cycle();
    req_valid = 4'b0000;
    @(negedge clk);
    check("single_rv_early", rsp_valid, 0);
    next_cycle();
    @(negedge clk);
    check("single_rv", rsp_valid, 1);
    check("single_data", rsp_data, exp_data);
    check("single_id", rsp_id, lane);
    next_cycle();
    @(negedge clk);
    check("single_rv_after", rsp_valid, 0);
    next_cycle();
  endtask

  initial begin
    reset     = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_rv", rsp_valid, 0);
    check("rst_ce", mul_ce, 1);
    check("rst_id", rsp_id, 0);
    check("rst_ready_idle", req_ready, 0);
    next_cycle();
    reset = 1'b1;

    // Lane 1 3*5, then lane 0 max operands (pointer at 2 wraps to 0).
    single(1, 17'd3, 15'd5, 4'b0010, 32'd15);
    single(0, 17'd131071, 15'd32767, 4'b0001, 32'd4294803457);

    // Pointer now 1: lane 2 alone, then lanes 0 and 3 together -> 3 before 0.
    set_lane(2, 17'd7, 15'd2);
    set_lane(3, 17'd4, 15'd9);
    set_lane(0, 17'd5, 15'd5);
    req_valid = 4'b0100;
    @(negedge clk);
    check("rr_ready_a", req_ready, 4'b0100);
    next_cycle();
    req_valid = 4'b1001;
    @(negedge clk);
    check("rr_ready_b", req_ready, 4'b1000);
    next_cycle();
    req_valid = 4'b0001;
    @(negedge clk);
    check("rr_ready_c", req_ready, 4'b0001);
    check("rr_rsp2_data", rsp_data, 14);
    check("rr_rsp2_id", rsp_id, 2);
    next_cycle();
    req_valid = 4'b0000;
    @(negedge clk);
    check("rr_rsp3_data", rsp_data, 36);
    check("rr_rsp3_id", rsp_id, 3);
    next_cycle();
    @(negedge clk);
    check("rr_rsp0_data", rsp_data, 25);
    check("rr_rsp0_id", rsp_id, 0);
    next_cycle();
    @(negedge clk);
    check("rr_drain", rsp_valid, 0);
    next_cycle();

    // Pointer 1 -> lane 3 alone, leaving pointer at 0 for the full-load run.
    single(3, 17'd2, 15'd3, 4'b1000, 32'd6);

    for (int i = 0; i < 4; i++) set_lane(i, 17'(i + 1), 15'd10);
    for (int c = 0; c < 15; c++) begin
      req_valid = (c < 12) ? 4'hF : 4'h0;
      rsp_ready = FlRspReady[c] != 0;
      @(negedge clk);
      check($sformatf("fl_ready_c%0d", c), req_ready, FlReady[c]);
      check($sformatf("fl_ce_c%0d", c), mul_ce, FlCe[c]);
      check($sformatf("fl_rv_c%0d", c), rsp_valid, FlRv[c]);
      if (FlRv[c] != 0) begin
        check($sformatf("fl_id_c%0d", c), rsp_id, FlId[c]);
        check($sformatf("fl_data_c%0d", c), rsp_data, (FlId[c] + 1) * 10);
      end
      next_cycle();
    end

    // Two products in flight (lanes 1 and 2), output stalled, then reset.
    rsp_ready = 1'b1;
    set_lane(1, 17'd2, 15'd2);
    set_lane(2, 17'd3, 15'd3);
    req_valid = 4'b0010;
    @(negedge clk);
    check("rst_mid_ready_a", req_ready, 4'b0010);
    next_cycle();
    req_valid = 4'b0100;
    @(negedge clk);
    check("rst_mid_ready_b", req_ready, 4'b0100);
    next_cycle();
    req_valid = 4'b0000;
    rsp_ready = 1'b0;
    reset     = 1'b0;
    @(negedge clk);
    check("rst_mid_rv_pre", rsp_valid, 1);
    check("rst_mid_id_pre", rsp_id, 1);
    check("rst_mid_data_pre", rsp_data, 4);
    next_cycle();
    reset     = 1'b1;
    rsp_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("rst_mid_rv_c%0d", c), rsp_valid, 0);
      check($sformatf("rst_mid_ce_c%0d", c), mul_ce, 1);
      next_cycle();
    end

    // Pointer back at 0: lane 3 alone still wins after searching 0..2.
    single(3, 17'd100, 15'd200, 4'b1000, 32'd20000);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/knn_mul_share_ctrl.md
Name: knn_mul_share_ctrl

Overview:
- Round-robin controller that time-shares one pipelined unsigned multiplier (17x15 -> 32, two ce-gated register stages) among NUM_REQ distance-computation lanes of the update_knn datapath.
- Accepts at most one operand pair per cycle from valid/ready requesters and drives the multiplier's ce/din0/din1.
- Tracks requester tags through the multiplier pipeline and returns each product with its requester id on a single valid/ready response port.
- Stalls the whole pipeline on response backpressure.

Parameters:
NUM_REQ, 4, number of requesting lanes (2..8)
ID_WIDTH, 2, width of requester index; must equal clog2(NUM_REQ)
A_WIDTH, 17, operand A width (multiplier din0)
B_WIDTH, 15, operand B width (multiplier din1)
P_WIDTH, 32, product width (multiplier dout)
MUL_LATENCY, 2, ce-qualified clock edges from din capture to valid dout

Ports:
clk  in  1  single clock, rising edge
reset  in  1  synchronous, active-low reset
req_valid  in  NUM_REQ  per-lane request valid
req_ready  out  NUM_REQ  per-lane accept; one-hot or zero
req_a  in  NUM_REQ*A_WIDTH  lane i operand A at bits [i*A_WIDTH +: A_WIDTH]
req_b  in  NUM_REQ*B_WIDTH  lane i operand B, packed the same way
mul_ce  out  1  multiplier clock enable
mul_din0  out  A_WIDTH  operand A to multiplier
mul_din1  out  B_WIDTH  operand B to multiplier
mul_dout  in  P_WIDTH  multiplier product
rsp_valid  out  1  product valid
rsp_ready  in  1  downstream accept
rsp_data  out  P_WIDTH  product (mul_dout pass-through)
rsp_id  out  ID_WIDTH  requester index of rsp_data

Behaviour:
- Stall: mul_ce = ~rsp_valid | rsp_ready (combinational; rsp_ready -> req_ready path is intentional). mul_ce low freezes multiplier, tag pipe, and rr pointer.
- Arbitration: when mul_ce=1, grant the first lane with req_valid=1 searching rr_ptr, rr_ptr+1, ..., wrapping modulo NUM_REQ. req_ready[g]=1 only for granted g, and only when mul_ce=1. All other lanes 0.
- Operand mux: mul_din0/mul_din1 = req_a/req_b of the granted lane; all zeros when no grant.
- Transfer: lane i's transfer occurs on a clock edge where req_valid[i] & req_ready[i]. On transfer, rr_ptr <= (g+1) mod NUM_REQ. Without a transfer, rr_ptr is held.
- Tag pipe: MUL_LATENCY stages of {vld, id}. Stage 0 loads {transfer, g} each ce edge (vld=0 bubble if no grant). Each stage shifts only when mul_ce=1.
- Output: rsp_valid = last-stage vld; rsp_id = last-stage id; rsp_data = mul_dout.
- Latency: a product accepted at ce edge k appears at rsp_valid after MUL_LATENCY ce edges. Unstalled, that is 2 cycles after the acceptance edge.
- Throughput: one result per cycle sustained.
- Ordering: responses are always in acceptance order.
- Stall integrity: while rsp_valid=1 and rsp_ready=0, rsp_data and rsp_id are held stable, and no request is accepted or lost.
- Bubbles: a last-stage vld=0 never stalls.
- Arithmetic: pure unsigned; no truncation at defaults, since 17+15=32. Max product is 131071*32767 = 4294803457.
- Reset (reset=0 at a clock edge):
  - rr_ptr=0 and all tag vld=0.
  - So rsp_valid=0, mul_ce=1, and req_ready follows requests immediately after reset.
  - rsp_id=0.
- Reset mid-operation: in-flight products are discarded, because their tags are cleared. Stale mul_dout values are ignored. There is no partial response.
- A lane may drop req_valid before it is granted without penalty. Operands are sampled only on the transfer edge.

Test Plan:
- Single lane 1 sends a=3, b=5; rsp_ready=1 -> req_ready[1] same cycle; rsp_valid=1, rsp_data=15, rsp_id=1 exactly 2 cycles after the accept edge; rsp_valid=0 the next cycle.
- Lane 0 sends a=131071, b=32767 -> rsp_data=4294803457, rsp_id=0.
- All 4 lanes valid continuously with distinct operands (lane i: a=i+1, b=10) -> grants 0,1,2,3,0,1,...; rsp sequence ids 0,1,2,3,... with data 10,20,30,40,10,...; one response per cycle.
- Round-robin pointer: lane 2 alone accepted, then lanes 0 and 3 valid together -> lane 3 granted first, then lane 0.
- Backpressure: under full load, hold rsp_ready=0 for 3 cycles while rsp_valid=1 -> mul_ce=0 and req_ready=0 for those cycles; rsp_data/rsp_id held; after release, no result dropped or duplicated; order preserved.
- Reset asserted with 2 products in flight -> rsp_valid=0 on the cycle after reset; those products are never emitted; a new request after reset returns the correct product with the correct id.
